// File: rtl/qpsk_integrate_dump_receiver.sv
// qpsk_integrate_dump_receiver
// Integrate-and-dump matched filter for a noisy QPSK I/Q stream. Each symbol
// of 2^SPS_LOG2 samples (aligned by an external sym_sync pulse) is summed, then
// divided by the symbol length and hard-sliced into two bits.
// Optional build macro NOISE_EST_EN adds a noise-variance estimator that
// averages (|avg| - AMP)^2 over 2^EST_LOG2 symbols. Without it, noise_var and
// noise_valid are tied to 0.
module qpsk_integrate_dump_receiver #(
  parameter int SPS_LOG2 = 3,
  parameter int AMP      = 1000,
  parameter int EST_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic        sym_sync,
  output logic        out_valid,
  output logic [1:0]  bits,
  output logic [15:0] i_avg,
  output logic [15:0] q_avg,
  output logic [31:0] noise_var,
  output logic        noise_valid
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + SPS_LOG2;
  localparam int PH_W   = SPS_LOG2 + 1;
  localparam int SPS    = 1 << SPS_LOG2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

  if (SPS_LOG2 < 0 || SPS_LOG2 > 8 || AMP < 1 || AMP > 32767 ||
      EST_LOG2 < 0 || EST_LOG2 > 24) begin : g_param_check
    $error("qpsk_integrate_dump_receiver: parameter out of legal range");
  end

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic signed [ACC_W-1:0]   acc_i_p0, acc_q_p0;
  logic signed [ACC_W-1:0]   acc_i_nxt, acc_q_nxt;
  logic signed [ACC_W-1:0]   base_i, base_q, sum_i, sum_q;
  logic [PH_W-1:0]           phase_p0, phase_nxt, phase_eff;
  logic                      accept, dump;
  logic signed [DATA_W-1:0]  i_s, q_s, avg_i, avg_q;

  assign i_s = i_in;
  assign q_s = q_in;

  // Divide a full symbol sum by SPS with an arithmetic shift; the result always fits DATA_W.
  function automatic logic signed [DATA_W-1:0] avg_fn(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    t = s >>> SPS_LOG2;
    return DATA_W'(t);
  endfunction

  // State, accumulator and phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WAIT_SYNC;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
      phase_p0 <= '0;
    end else begin
      state    <= state_nxt;
      acc_i_p0 <= acc_i_nxt;
      acc_q_p0 <= acc_q_nxt;
      phase_p0 <= phase_nxt;
    end
  end

  // Next-state logic: a sync sample restarts the symbol from phase 0 in either
  // state, so the partial sum is dropped and the sync sample may itself dump.
  always_comb begin
    state_nxt = state;
    acc_i_nxt = acc_i_p0;
    acc_q_nxt = acc_q_p0;
    phase_nxt = phase_p0;
    accept    = in_valid && (sym_sync || (state == RUN));
    phase_eff = sym_sync ? '0 : phase_p0;
    base_i    = sym_sync ? ACC_W'(0) : acc_i_p0;
    base_q    = sym_sync ? ACC_W'(0) : acc_q_p0;
    sum_i     = base_i + ACC_W'(i_s);
    sum_q     = base_q + ACC_W'(q_s);
    dump      = accept && (phase_eff == PH_LAST);
    avg_i     = avg_fn(sum_i);
    avg_q     = avg_fn(sum_q);
    if (accept) begin
      state_nxt = RUN;
      if (dump) begin
        acc_i_nxt = '0;
        acc_q_nxt = '0;
        phase_nxt = '0;
      end else begin
        acc_i_nxt = sum_i;
        acc_q_nxt = sum_q;
        phase_nxt = phase_eff + PH_W'(1);
      end
    end
  end

  // ---- stage p1: registered symbol result, one cycle after the last sample ----
  // Output register: pulse out_valid and capture averages/bits on each dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      bits      <= '0;
      i_avg     <= '0;
      q_avg     <= '0;
    end else begin
      out_valid <= dump;
      if (dump) begin
        i_avg <= avg_i;
        q_avg <= avg_q;
        bits  <= {avg_i[DATA_W-1], avg_q[DATA_W-1]};
      end
    end
  end

`ifdef NOISE_EST_EN
  localparam int EACC_W = 32 + EST_LOG2;
  localparam int EN_W   = EST_LOG2 + 1;
  localparam logic [EN_W-1:0] EST_LAST = EN_W'((1 << EST_LOG2) - 1);

  logic [EACC_W-1:0] est_acc, est_sum;
  logic [EN_W-1:0]   est_cnt;
  logic [31:0]       term;

  // Squared distance of one axis from the nominal amplitude; |-32768| is 32768.
  function automatic logic [31:0] err_sq(input logic signed [DATA_W-1:0] a);
    logic signed [16:0] w;
    logic signed [17:0] e;
    logic signed [35:0] p;
    w = 17'(a);
    if (w < 0) w = -w;
    e = 18'(w) - 18'(AMP);
    p = 36'(e) * 36'(e);
    return 32'(p);
  endfunction

  // Window mean, clamped to 32 bits.
  function automatic logic [31:0] sat_fn(input logic [EACC_W-1:0] a);
    logic [EACC_W-1:0] s;
    s = a >> EST_LOG2;
    if (s > EACC_W'(32'hFFFF_FFFF)) return 32'hFFFF_FFFF;
    return 32'(s);
  endfunction

  assign term    = err_sq(avg_i) + err_sq(avg_q);
  assign est_sum = est_acc + EACC_W'(term);

  // Estimator: accumulate one term per dump; publish and restart every 2^EST_LOG2 symbols.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      est_acc     <= '0;
      est_cnt     <= '0;
      noise_var   <= '0;
      noise_valid <= 1'b0;
    end else begin
      noise_valid <= 1'b0;
      if (dump) begin
        if (est_cnt == EST_LAST) begin
          noise_var   <= sat_fn(est_sum);
          noise_valid <= 1'b1;
          est_acc     <= '0;
          est_cnt     <= '0;
        end else begin
          est_acc <= est_sum;
          est_cnt <= est_cnt + EN_W'(1);
        end
      end
    end
  end
`else
  assign noise_var   = '0;
  assign noise_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qpsk_integrate_dump_receiver.sv
// Scoreboard bench for qpsk_integrate_dump_receiver (default parameters).
module tb_qpsk_integrate_dump_receiver;

  localparam int AMP = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        sym_sync = 1'b0;
  logic [15:0] i_in = '0;
  logic [15:0] q_in = '0;
  logic        out_valid;
  logic [1:0]  bits;
  logic [15:0] i_avg, q_avg;
  logic [31:0] noise_var;
  logic        noise_valid;

  qpsk_integrate_dump_receiver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .sym_sync(sym_sync), .out_valid(out_valid), .bits(bits), .i_avg(i_avg),
    .q_avg(q_avg), .noise_var(noise_var), .noise_valid(noise_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  b;
    logic [15:0] i;
    logic [15:0] q;
    int          cyc;
    logic        nv;
    logic [31:0] nvar;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;
  int n_noise = 0;
  longint est_acc = 0;
  int est_n = 0;
  logic [31:0] model_nvar = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every out_valid pops one expected symbol.
  exp_t e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid === 1'b1) begin
        n_out++;
        if (noise_valid === 1'b1) n_noise++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: out_valid=1 at cycle %0d, required no output", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bits !== e.b) begin errors++; $display("FAIL bits: got %b required %b", bits, e.b); end
          checks++;
          if (i_avg !== e.i) begin errors++; $display("FAIL i_avg: got %0d required %0d", $signed(i_avg), $signed(e.i)); end
          checks++;
          if (q_avg !== e.q) begin errors++; $display("FAIL q_avg: got %0d required %0d", $signed(q_avg), $signed(e.q)); end
          checks++;
          if (cyc !== e.cyc) begin errors++; $display("FAIL latency: out at cycle %0d required %0d", cyc, e.cyc); end
          checks++;
          if (noise_valid !== e.nv) begin errors++; $display("FAIL noise_valid: got %b required %b", noise_valid, e.nv); end
          checks++;
          if (noise_var !== e.nvar) begin errors++; $display("FAIL noise_var: got %0d required %0d", noise_var, e.nvar); end
        end
      end else begin
        checks++;
        if (noise_valid !== 1'b0) begin
          errors++; $display("FAIL noise_valid_idle: got %b required 0", noise_valid);
        end
      end
    end
  end

  task automatic model_reset();
    est_acc = 0; est_n = 0; model_nvar = '0;
  endtask

  // Queue the expected result of a symbol whose last sample was just driven.
  task automatic push_sym(input int ia, input int qa);
    exp_t x;
    longint ei, eq;
    x.b = {ia < 0, qa < 0};
    x.i = 16'(ia);
    x.q = 16'(qa);
    x.cyc = cyc + 1;
    x.nv = 1'b0;
`ifdef NOISE_EST_EN
    ei = longint'(ia < 0 ? -ia : ia) - AMP;
    eq = longint'(qa < 0 ? -qa : qa) - AMP;
    est_acc += ei * ei + eq * eq;
    est_n++;
    if (est_n == 64) begin
      x.nv = 1'b1;
      model_nvar = ((est_acc / 64) > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(est_acc / 64);
      est_acc = 0;
      est_n = 0;
    end
    x.nvar = model_nvar;
`else
    ei = 0; eq = ei;
    x.nvar = '0;
`endif
    sb.push_back(x);
  endtask

  task automatic drive(input logic v, input logic s, input int i, input int q);
    @(negedge clk);
    in_valid = v; sym_sync = s; i_in = 16'(i); q_in = 16'(q);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
  endtask

  // One 8-sample symbol; optional bubble (random data, in_valid=0) after each sample.
  task automatic send_sym(input int i, input int q, input bit bub, input bit sync);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, sync && (k == 0), i, q);
      if (k == 7) push_sym(i, q);
      else if (bub) drive(1'b0, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (bits !== 2'b00) begin errors++; $display("FAIL rst_bits: got %b required 00", bits); end
    checks++; if (i_avg !== 16'd0 || q_avg !== 16'd0) begin errors++; $display("FAIL rst_avg: got %0d/%0d required 0/0", i_avg, q_avg); end
    checks++; if (noise_var !== 32'd0 || noise_valid !== 1'b0) begin errors++; $display("FAIL rst_noise: got %0d/%b required 0/0", noise_var, noise_valid); end
    rst = 1'b1;
  endtask

  task automatic test_no_sync();
    int n0;
    n0 = n_out;
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1000, 1000);
    idle(3);
    checks++; if (n_out !== n0) begin errors++; $display("FAIL no_sync: got %0d outputs required 0", n_out - n0); end
  endtask

  task automatic test_basic();
    int n0;
    n0 = n_out;
    send_sym(1000, -1000, 1'b0, 1'b1);
    send_sym(-1000, -1000, 1'b0, 1'b1);
    idle(3);
    checks++; if (n_out - n0 !== 2) begin errors++; $display("FAIL basic_count: got %0d required 2", n_out - n0); end
    checks++; if (bits !== 2'b11 || i_avg !== 16'hFC18) begin errors++; $display("FAIL basic_hold: got %b/%0d required 11/-1000", bits, $signed(i_avg)); end
  endtask

  task automatic test_bubbles();
    int n0;
    n0 = n_out;
    send_sym(1000, -1000, 1'b1, 1'b1);
    idle(3);
    checks++; if (n_out - n0 !== 1) begin errors++; $display("FAIL bubble_count: got %0d required 1", n_out - n0); end
    checks++; if (bits !== 2'b01 || i_avg !== 16'd1000) begin errors++; $display("FAIL bubble_hold: got %b/%0d required 01/1000", bits, $signed(i_avg)); end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = n_out;
    drive(1'b1, 1'b1, 500, 500);
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 500, 500);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    checks++; if (bits !== 2'b00 || i_avg !== 16'd0) begin errors++; $display("FAIL mid_rst_data: got %b/%0d required 00/0", bits, i_avg); end
    checks++; if (noise_var !== 32'd0) begin errors++; $display("FAIL mid_rst_noise: got %0d required 0", noise_var); end
    rst = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 700, 700);
    idle(3);
    checks++; if (n_out !== n0) begin errors++; $display("FAIL mid_rst_ignore: got %0d outputs required 0", n_out - n0); end
  endtask

  task automatic test_resync();
    int n0;
    n0 = n_out;
    drive(1'b1, 1'b1, -3000, 0);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, -3000, 0);
    send_sym(1200, 800, 1'b0, 1'b1);
    idle(3);
    checks++; if (n_out - n0 !== 1) begin errors++; $display("FAIL resync_count: got %0d required 1", n_out - n0); end
    checks++; if (bits !== 2'b00 || q_avg !== 16'd800) begin errors++; $display("FAIL resync_hold: got %b/%0d required 00/800", bits, q_avg); end
  endtask

  task automatic test_back_to_back();
    int n0, nn0;
    logic [31:0] want;
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
    n0 = n_out; nn0 = n_noise;
    for (int s = 0; s < 64; s++) send_sym(1100, 900, 1'b0, s == 0);
    idle(3);
    checks++; if (n_out - n0 !== 64) begin errors++; $display("FAIL b2b_count: got %0d required 64", n_out - n0); end
`ifdef NOISE_EST_EN
    want = 32'd20000;
    checks++; if (n_noise - nn0 !== 1) begin errors++; $display("FAIL noise_pulses: got %0d required 1", n_noise - nn0); end
`else
    want = 32'd0;
    checks++; if (n_noise - nn0 !== 0) begin errors++; $display("FAIL noise_pulses: got %0d required 0", n_noise - nn0); end
`endif
    checks++; if (noise_var !== want) begin errors++; $display("FAIL noise_hold: got %0d required %0d", noise_var, want); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_sync();
    test_basic();
    test_bubbles();
    test_reset_mid();
    test_resync();
    test_back_to_back();
    idle(2);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL missing_out: got %0d pending symbols required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
